// File: rtl/johnson_phase_monitor.sv
// Johnson counter phase monitor: decodes a twisted-ring code to a phase index,
// tracks sequence lock, counts full rotations and latches the first bad code.
module johnson_phase_monitor #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 4,
    parameter int CW       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              jc_in,
    input  logic                      err_clr,
    output logic [$clog2(2*N)-1:0]    phase,
    output logic                      phase_valid,
    output logic                      locked,
    output logic                      err,
    output logic [N-1:0]              err_code,
    output logic [CW-1:0]             cycle_cnt
);

    localparam int PW = $clog2(2*N);
    localparam int L  = 2 * N;

    typedef enum logic [1:0] {
        SEARCH,
        LOCKED,
        ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          pvalid_q, pvalid_d;
    logic [3:0]    match_q, match_d;
    logic [N-1:0]  ecode_q, ecode_d;
    logic [CW-1:0] cyc_q, cyc_d;

    logic          legal;
    logic          succ;
    logic [PW-1:0] idx;
    logic [PW-1:0] nxt_exp;

    always_comb begin
        logic msb_form;
        logic lsb_form;
        int   ones;
        msb_form = 1'b1;
        lsb_form = 1'b1;
        ones     = 0;
        for (int i = 0; i < N - 1; i++) begin
            if (jc_in[i] && !jc_in[i+1]) msb_form = 1'b0;
            if (jc_in[i+1] && !jc_in[i]) lsb_form = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            ones = ones + int'(jc_in[i]);
        end
        legal = msb_form || lsb_form;
        if (jc_in[N-1] || (jc_in == '0)) begin
            idx = PW'(ones);
        end else begin
            idx = PW'(L - ones);
        end
    end

    // Expected successor of the previous sample, wrapping at 2N.
    assign nxt_exp = (phase_q == PW'(L - 1)) ? '0 : phase_q + PW'(1);
    assign succ    = legal && pvalid_q && (idx == nxt_exp);

    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        ecode_d  = ecode_q;
        cyc_d    = cyc_q;
        phase_d  = legal ? idx : phase_q;
        pvalid_d = legal;
        unique case (state_q)
            SEARCH: begin
                if (succ) begin
                    if (match_q + 4'd1 == 4'(LOCK_CNT)) begin
                        state_d = LOCKED;
                        match_d = '0;
                    end else begin
                        match_d = match_q + 4'd1;
                    end
                end else begin
                    match_d = '0;
                end
            end
            LOCKED: begin
                if (succ) begin
                    if (idx == '0) cyc_d = cyc_q + CW'(1);
                end else begin
                    state_d = ERROR;
                    ecode_d = jc_in;
                end
            end
            ERROR: begin
                if (err_clr) begin
                    state_d = SEARCH;
                    match_d = '0;
                    cyc_d   = '0;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SEARCH;
            phase_q  <= '0;
            pvalid_q <= 1'b0;
            match_q  <= '0;
            ecode_q  <= '0;
            cyc_q    <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            pvalid_q <= pvalid_d;
            match_q  <= match_d;
            ecode_q  <= ecode_d;
            cyc_q    <= cyc_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = pvalid_q;
    assign locked      = (state_q == LOCKED);
    assign err         = (state_q == ERROR);
    assign err_code    = ecode_q;
    assign cycle_cnt   = cyc_q;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Self-checking bench for johnson_phase_monitor: sequence-table model plus
// directed scenarios covering lock, rotations, errors, clear and async reset.
module tb_johnson_phase_monitor;

    localparam int N  = 4;
    localparam int L  = 2 * N;
    localparam int LC = 4;
    localparam int CW = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] jc_in;
    logic         err_clr;
    logic [2:0]   phase;
    logic         phase_valid;
    logic         locked;
    logic         err;
    logic [N-1:0] err_code;
    logic [CW-1:0] cycle_cnt;

    int checks = 0;
    int failures = 0;

    johnson_phase_monitor #(.N(N), .LOCK_CNT(LC), .CW(CW)) dut (
        .clk(clk),
        .rst(rst),
        .jc_in(jc_in),
        .err_clr(err_clr),
        .phase(phase),
        .phase_valid(phase_valid),
        .locked(locked),
        .err(err),
        .err_code(err_code),
        .cycle_cnt(cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Legal codes in ring order, generated by stepping the counter itself.
    logic [N-1:0] seq [L];
    initial begin
        logic [N-1:0] q;
        q = '0;
        for (int i = 0; i < L; i++) begin
            seq[i] = q;
            q = {~q[0], q[N-1:1]};
        end
    end

    function automatic int idx_of(logic [N-1:0] c);
        for (int i = 0; i < L; i++) if (seq[i] == c) return i;
        return -1;
    endfunction

    int           m_phase;
    bit           m_pv;
    int           m_st;
    int           m_match;
    logic [N-1:0] m_ec;
    int           m_cc;

    always @(posedge clk or posedge rst) begin
        int  i;
        bit  s;
        if (rst) begin
            m_phase = 0; m_pv = 0; m_st = 0;
            m_match = 0; m_ec = '0; m_cc = 0;
        end else begin
            i = idx_of(jc_in);
            s = (i >= 0) && m_pv && (i == (m_phase + 1) % L);
            case (m_st)
                0: begin
                    if (s) begin
                        m_match++;
                        if (m_match == LC) begin
                            m_st = 1;
                            m_match = 0;
                        end
                    end else m_match = 0;
                end
                1: begin
                    if (s) begin
                        if (i == 0) m_cc = (m_cc + 1) % (1 << CW);
                    end else begin
                        m_st = 2;
                        m_ec = jc_in;
                    end
                end
                default: begin
                    if (err_clr) begin
                        m_st = 0; m_match = 0; m_cc = 0;
                    end
                end
            endcase
            if (i >= 0) begin
                m_phase = i;
                m_pv = 1;
            end else m_pv = 0;
        end
    end

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_phase", int'(phase), m_phase);
            chk("m_pvalid", int'(phase_valid), int'(m_pv));
            chk("m_locked", int'(locked), int'(m_st == 1));
            chk("m_err", int'(err), int'(m_st == 2));
            chk("m_errcode", int'(err_code), int'(m_ec));
            chk("m_cycle", int'(cycle_cnt), m_cc);
            chk("m_exclusive", int'(locked && err), 0);
        end
    end

    task automatic step(logic [N-1:0] c, logic clr);
        @(negedge clk);
        jc_in = c;
        err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(string nm);
        chk({nm, "_phase"}, int'(phase), 0);
        chk({nm, "_pv"}, int'(phase_valid), 0);
        chk({nm, "_locked"}, int'(locked), 0);
        chk({nm, "_err"}, int'(err), 0);
        chk({nm, "_ec"}, int'(err_code), 0);
        chk({nm, "_cc"}, int'(cycle_cnt), 0);
    endtask

    initial begin
        rst = 1'b0;
        jc_in = '0;
        err_clr = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Test 1: first five codes, lock after the fourth transition
        step(4'b0000, 0); chk("t1_p0", int'(phase), 0);
        chk("t1_pv", int'(phase_valid), 1);
        step(4'b1000, 0); chk("t1_p1", int'(phase), 1);
        step(4'b1100, 0); chk("t1_p2", int'(phase), 2);
        step(4'b1110, 0); chk("t1_p3", int'(phase), 3);
        chk("t1_notlocked", int'(locked), 0);
        step(4'b1111, 0); chk("t1_p4", int'(phase), 4);
        chk("t1_locked", int'(locked), 1);
        chk("t1_err", int'(err), 0);

        // Test 2: two full rotations
        for (int k = 5; k <= 16; k++) step(seq[k % L], 0);
        chk("t2_cc", int'(cycle_cnt), 2);
        chk("t2_phase", int'(phase), 0);
        step(4'b1000, 0);

        // Test 3: illegal code while locked
        step(4'b1010, 0);
        chk("t3_err", int'(err), 1);
        chk("t3_locked", int'(locked), 0);
        chk("t3_pv", int'(phase_valid), 0);
        chk("t3_ec", int'(err_code), 4'b1010);
        chk("t3_phase", int'(phase), 1);
        chk("t3_cc", int'(cycle_cnt), 2);
        step(4'b0000, 0);
        chk("t3_frozen", int'(err_code), 4'b1010);

        // Test 5: clear, relock, err_clr while locked has no effect
        step(4'b0000, 1);
        chk("t5_err", int'(err), 0);
        chk("t5_cc", int'(cycle_cnt), 0);
        chk("t5_ec_kept", int'(err_code), 4'b1010);
        step(4'b1000, 0);
        step(4'b1100, 0);
        step(4'b1110, 0);
        chk("t5_notyet", int'(locked), 0);
        step(4'b1111, 0);
        chk("t5_locked", int'(locked), 1);
        step(4'b0111, 1);
        chk("t5_clr_ign", int'(locked), 1);
        step(4'b0011, 0);
        step(4'b0001, 0);
        step(4'b0000, 0);
        chk("t5_cc1", int'(cycle_cnt), 1);
        step(4'b1000, 0);

        // Test 4: skipped step while locked
        step(4'b1110, 0);
        chk("t4_err", int'(err), 1);
        chk("t4_ec", int'(err_code), 4'b1110);
        chk("t4_phase", int'(phase), 3);
        chk("t4_pv", int'(phase_valid), 1);

        // Relock and build cycle_cnt up to 3
        step(4'b0000, 1);
        for (int k = 1; k <= 24; k++) step(seq[k % L], 0);
        chk("t6_cc3", int'(cycle_cnt), 3);
        chk("t6_locked", int'(locked), 1);

        // Test 6: asynchronous reset between edges
        @(posedge clk);
        #2 rst = 1'b1;
        #1 all_zero("async");
        @(negedge clk);
        rst = 1'b0;
        step(4'b0000, 0);
        step(4'b1000, 0);
        step(4'b1100, 0);
        step(4'b1110, 0);
        chk("t6_relock_no", int'(locked), 0);
        step(4'b1111, 0);
        chk("t6_relock", int'(locked), 1);

        // Error-causing sample together with err_clr: error wins
        step(4'b1010, 1);
        chk("t7_err", int'(err), 1);
        chk("t7_ec", int'(err_code), 4'b1010);
        step(4'b0111, 0);
        chk("t7_stay", int'(err), 1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/johnson_phase_monitor.md
Name: johnson_phase_monitor

Overview:
Downstream consumer of the 4-bit twisted-ring (Johnson) counter. Samples the counter's code every clock and decodes it to a binary phase index. Checks that each code is legal and that the sequence advances by exactly one step per clock. Provides lock status, a full-rotation count, and a sticky error with the offending code captured for debug.

Parameters:
N, 4, Johnson counter width (number of bits in jc_in); sequence length is 2N.
LOCK_CNT, 4, consecutive legal successor transitions required to declare lock (1..15).
CW, 8, width of cycle_cnt.
(localparam PW = $clog2(2N); equals 3 for N=4.)

Ports:
clk  input  1  system clock; all state is updated on the rising edge.
rst  input  1  asynchronous, active-high reset.
jc_in  input  N  Johnson code from the ring counter.
err_clr  input  1  clears the sticky error and restarts the lock search.
phase  output  PW  decoded index of the last sampled code.
phase_valid  output  1  last sampled code was legal.
locked  output  1  sequence tracking is established.
err  output  1  sticky sequence/code error.
err_code  output  N  jc_in value that caused entry to ERROR.
cycle_cnt  output  CW  full rotations completed while locked.

Behaviour:
- Reset (async, immediate): phase=0, phase_valid=0, locked=0, err=0, err_code=0, cycle_cnt=0, match_cnt=0, state=SEARCH.
- Counter convention: next = {~q[0], q[N-1:1]}.
  - N=4 sequence: 0000→1000→1100→1110→1111→0111→0011→0001→0000.
  - Indices 0..7 in that order.
- Legal code: ones contiguous from the MSB (1..10..0, including all-zeros), or ones contiguous from the LSB (0..01..1).
- Decode, with k = popcount:
  - MSB=1 or code==0: index = k.
  - Otherwise: index = 2N − k.
- Latency: jc_in sampled at edge t; phase and phase_valid reflect it after edge t (one register stage).
- Illegal code: phase_valid=0 and phase holds its previous value.
- Successor test: legal AND previous sample legal AND index == (phase+1) mod 2N.
- FSM states: SEARCH, LOCKED, ERROR.
- SEARCH:
  - Successor sample: match_cnt++.
  - Any other sample: match_cnt=0.
  - When match_cnt reaches LOCK_CNT: go to LOCKED, and locked=1 after that same edge.
- LOCKED:
  - Successor sample: stay; if the new index==0, cycle_cnt++ (wraps modulo 2^CW).
  - Illegal or non-successor sample (including a held or repeated code): go to ERROR; err=1, locked=0, err_code=jc_in, all after that edge.
- ERROR:
  - Stays in ERROR; decode keeps running; err_code and cycle_cnt are frozen.
  - err_clr=1: go to SEARCH; err=0, match_cnt=0, cycle_cnt=0, err_code retained.
  - The sample taken at the clearing edge serves only as the successor reference for the next sample.
- err_clr outside ERROR: ignored.
- err_clr in the same cycle as an error-causing sample while LOCKED: the error wins (go to ERROR); err_clr is not remembered.
- Reset mid-operation: all state returns to its reset value immediately; no pending lock or count survives.
- locked and err are never both 1.

Test Plan:
1. Reset 2 cycles, then jc_in follows 0000,1000,1100,1110,1111 on successive edges -> phase 0,1,2,3,4; phase_valid=1 from the first edge; locked=1 after the 1111 edge (4 transitions); err=0.
2. Continue the sequence through 2 full rotations after lock -> cycle_cnt=2; phase wraps 7→0 on each 0001→0000 step.
3. While locked, drive 1010 -> after that edge: err=1, locked=0, phase_valid=0, err_code=1010, phase holds its prior value, cycle_cnt frozen.
4. While locked at 1000, drive 1110 (step skipped) -> err=1, err_code=1110, phase=3, phase_valid=1.
5. In ERROR, pulse err_clr 1 cycle, then resume the legal sequence -> err=0, cycle_cnt=0, locked=1 after 4 successor transitions; err_clr pulsed while locked -> no effect.
6. Assert rst asynchronously mid-cycle while locked with cycle_cnt=3 -> all outputs 0 immediately, before the next edge; relock requires 4 new transitions.
